// File: rtl/rx_sync_ctrl.sv
// Receive-side frame synchroniser: hunts for a preamble, waits for the SFD, then assembles
// LSB-first data words until end-of-frame. Define RX_SYNC_TIMEOUT_EN to enable the SYNC timeout.
module rx_sync_ctrl #(
  parameter int SFD_TIMEOUT = 64,
  parameter int BYTE_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_valid,
  input  logic              bit_in,
  input  logic              pre_h,
  input  logic              sfd_h,
  input  logic              eof_h,
  output logic              corr_enb,
  output logic              corr_rst,
  output logic              cardet,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_write,
  output logic              rx_done,
  output logic              rx_error,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    SYNC  = 2'd1,
    RECV  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(BYTE_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_W - 1);

  state_t            state_q;
  logic [CNT_W-1:0]  bit_cnt;
  logic [BYTE_W-1:0] shreg;
  logic [BYTE_W-1:0] word_next;

`ifdef RX_SYNC_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(SFD_TIMEOUT - 1);
  logic [7:0] to_cnt;
`endif

  // Bits arrive LSB first, so each new bit enters at the MSB and the word shifts right.
  assign word_next = {bit_in, shreg[BYTE_W-1:1]};
  assign corr_enb  = bit_valid;
  assign cardet    = (state_q == SYNC) || (state_q == RECV);
  assign state     = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= HUNT;
      bit_cnt  <= '0;
      shreg    <= '0;
      rx_data  <= '0;
      rx_write <= 1'b0;
      rx_done  <= 1'b0;
      rx_error <= 1'b0;
      corr_rst <= 1'b0;
`ifdef RX_SYNC_TIMEOUT_EN
      to_cnt   <= '0;
`endif
    end else begin
      rx_write <= 1'b0;
      rx_done  <= 1'b0;
      rx_error <= 1'b0;
      corr_rst <= 1'b0;
      case (state_q)
        HUNT: begin
          if (bit_valid && pre_h) begin
            state_q <= SYNC;
`ifdef RX_SYNC_TIMEOUT_EN
            to_cnt  <= '0;
`endif
          end
        end
        SYNC: begin
          if (bit_valid) begin
            // SFD takes priority over a timeout expiring on the same strobe.
            if (sfd_h) begin
              state_q <= RECV;
              bit_cnt <= '0;
            end else begin
`ifdef RX_SYNC_TIMEOUT_EN
              if (to_cnt == TO_LAST) begin
                rx_error <= 1'b1;
                corr_rst <= 1'b1;
                state_q  <= FLUSH;
              end else begin
                to_cnt <= to_cnt + 8'd1;
              end
`else
              if (!pre_h) begin
                state_q <= HUNT;
              end
`endif
            end
          end
        end
        RECV: begin
          if (bit_valid) begin
            shreg <= word_next;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt  <= '0;
              rx_data  <= word_next;
              rx_write <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
            // corr_rst is raised on FLUSH entry so it is high for exactly the FLUSH cycle.
            if (eof_h) begin
              state_q  <= FLUSH;
              corr_rst <= 1'b1;
              if (bit_cnt == LAST_BIT) begin
                rx_done <= 1'b1;
              end else begin
                rx_error <= 1'b1;
              end
            end
          end
        end
        FLUSH: begin
          state_q <= HUNT;
        end
        default: begin
          state_q <= HUNT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_sync_ctrl.sv
// Self-checking bench for rx_sync_ctrl: frame-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_rx_sync_ctrl;
  localparam int W  = 8;
  localparam int TO = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         bit_valid = 1'b0;
  logic         bit_in = 1'b0;
  logic         pre_h = 1'b0;
  logic         sfd_h = 1'b0;
  logic         eof_h = 1'b0;
  logic         corr_enb, corr_rst, cardet, rx_write, rx_done, rx_error;
  logic [W-1:0] rx_data;
  logic [1:0]   state;

  rx_sync_ctrl #(.SFD_TIMEOUT(TO), .BYTE_W(W)) dut (
    .clk(clk), .reset(reset), .bit_valid(bit_valid), .bit_in(bit_in),
    .pre_h(pre_h), .sfd_h(sfd_h), .eof_h(eof_h),
    .corr_enb(corr_enb), .corr_rst(corr_rst), .cardet(cardet),
    .rx_data(rx_data), .rx_write(rx_write), .rx_done(rx_done),
    .rx_error(rx_error), .state(state)
  );

  // clock/reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int w_cnt = 0, d_cnt = 0, e_cnt = 0, r_cnt = 0, both_cnt = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: frame-level view of the receiver
  int        m_mode = 0;      // 0 idle, 1 waiting for SFD, 2 receiving, 3 flushing
  int        m_sync_strobes = 0;
  logic      m_bits[$];
  logic [W-1:0] e_data = '0;
  logic      e_write = 0, e_done = 0, e_error = 0;
  bit        model_valid = 0;

  always @(posedge clk) begin
    e_write = 0; e_done = 0; e_error = 0;
    model_valid = 1;
    if (reset) begin
      m_mode = 0; m_sync_strobes = 0; m_bits.delete(); e_data = '0;
    end else if (m_mode == 3) begin
      m_mode = 0;
    end else if (bit_valid) begin
      if (m_mode == 0) begin
        if (pre_h) begin m_mode = 1; m_sync_strobes = 0; end
      end else if (m_mode == 1) begin
        if (sfd_h) begin
          m_mode = 2; m_bits.delete();
        end else begin
`ifdef RX_SYNC_TIMEOUT_EN
          m_sync_strobes++;
          if (m_sync_strobes >= TO) begin e_error = 1; m_mode = 3; end
`else
          if (!pre_h) m_mode = 0;
`endif
        end
      end else begin
        m_bits.push_back(bit_in);
        if (m_bits.size() == W) begin
          for (int i = 0; i < W; i++) e_data[i] = m_bits[i];
          e_write = 1;
          m_bits.delete();
        end
        if (eof_h) begin
          if (m_bits.size() == 0) e_done = 1; else e_error = 1;
          m_bits.delete();
          m_mode = 3;
        end
      end
    end
  end

  // compare process and scoreboard, away from the active edge
  always @(negedge clk) begin
    if (model_valid) begin
      check("state",    32'(state),    32'(m_mode));
      check("cardet",   32'(cardet),   32'(m_mode == 1 || m_mode == 2));
      check("corr_rst", 32'(corr_rst), 32'(m_mode == 3));
      check("corr_enb", 32'(corr_enb), 32'(bit_valid));
      check("rx_write", 32'(rx_write), 32'(e_write));
      check("rx_done",  32'(rx_done),  32'(e_done));
      check("rx_error", 32'(rx_error), 32'(e_error));
      check("rx_data",  32'(rx_data),  32'(e_data));
    end
    if (rx_write) begin
      w_cnt++;
      if (exp_q.size() == 0) check("unexpected_write", 32'(rx_data), 32'hFFFF_FFFF);
      else check("sb_word", 32'(rx_data), 32'(exp_q.pop_front()));
    end
    if (rx_done)  d_cnt++;
    if (rx_error) e_cnt++;
    if (corr_rst) r_cnt++;
    if (rx_write && rx_done) both_cnt++;
  end

  // driver tasks
  task automatic strobe(input logic b, input logic p, input logic s, input logic e);
    @(posedge clk); #1;
    bit_valid = 1; bit_in = b; pre_h = p; sfd_h = s; eof_h = e;
    @(posedge clk); #1;
    bit_valid = 0; bit_in = 0; pre_h = 0; sfd_h = 0; eof_h = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [W-1:0] d, input bit eof_last);
    for (int i = 0; i < W; i++) strobe(d[i], 0, 0, eof_last && (i == W - 1));
  endtask

  task automatic clear_counts();
    w_cnt = 0; d_cnt = 0; e_cnt = 0; r_cnt = 0; both_cnt = 0;
  endtask

  initial begin
    idle(3);
    check("reset_state", 32'(state), 32'd0);
    check("reset_data", 32'(rx_data), 32'd0);
    check("reset_strobes", 32'({rx_write, rx_done, rx_error, corr_rst, cardet}), 32'd0);
    reset = 0;
    idle(2);

    // two-word frame, eof on the final bit
    clear_counts();
    exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
    strobe(0, 1, 0, 0);
    check("sync_state", 32'(state), 32'd1);
    strobe(0, 0, 1, 0);
    check("recv_state", 32'(state), 32'd2);
    send_byte(8'hA5, 0);
    send_byte(8'h3C, 1);
    idle(3);
    check("f1_writes", 32'(w_cnt), 32'd2);
    check("f1_done", 32'(d_cnt), 32'd1);
    check("f1_error", 32'(e_cnt), 32'd0);
    check("f1_corr_rst", 32'(r_cnt), 32'd1);
    check("f1_state", 32'(state), 32'd0);
    check("f1_data", 32'(rx_data), 32'h3C);

    // eof on the 3rd bit of a word
    clear_counts();
    strobe(0, 1, 0, 0);
    strobe(0, 0, 1, 0);
    strobe(1, 0, 0, 0);
    strobe(0, 0, 0, 0);
    strobe(1, 0, 0, 1);
    check("part_flush", 32'(state), 32'd3);
    idle(2);
    check("part_error", 32'(e_cnt), 32'd1);
    check("part_writes", 32'(w_cnt), 32'd0);
    check("part_corr_rst", 32'(r_cnt), 32'd1);
    check("part_state", 32'(state), 32'd0);

    // SYNC with no SFD
    clear_counts();
    strobe(0, 1, 0, 0);
`ifdef RX_SYNC_TIMEOUT_EN
    for (int i = 0; i < TO - 1; i++) strobe(0, 0, 0, 0);
    check("to_pre_state", 32'(state), 32'd1);
    strobe(0, 0, 0, 0);
    check("to_flush", 32'(state), 32'd3);
    idle(2);
    check("to_error", 32'(e_cnt), 32'd1);
    check("to_corr_rst", 32'(r_cnt), 32'd1);
`else
    for (int i = 0; i < TO; i++) strobe(0, 1, 0, 0);
    check("nto_state", 32'(state), 32'd1);
    strobe(0, 0, 0, 0);
    idle(2);
    check("nto_hunt", 32'(state), 32'd0);
    check("nto_error", 32'(e_cnt), 32'd0);
`endif

    // SFD on the last allowed strobe, then 0xFF with eof on its 8th bit
    clear_counts();
    exp_q.push_back(8'hFF);
    strobe(0, 1, 0, 0);
    for (int i = 0; i < TO - 1; i++) strobe(0, 1, 0, 0);
    strobe(0, 1, 1, 0);
    check("sfd_edge_state", 32'(state), 32'd2);
    check("sfd_edge_error", 32'(e_cnt), 32'd0);
    send_byte(8'hFF, 1);
    idle(3);
    check("ff_both", 32'(both_cnt), 32'd1);
    check("ff_data", 32'(rx_data), 32'hFF);
    check("ff_error", 32'(e_cnt), 32'd0);

    // reset after the 5th bit, then a clean frame
    clear_counts();
    strobe(0, 1, 0, 0);
    strobe(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) strobe(1, 0, 0, 0);
    reset = 1;
    idle(2);
    check("rst_state", 32'(state), 32'd0);
    check("rst_data", 32'(rx_data), 32'd0);
    reset = 0;
    idle(2);
    check("rst_strobes", 32'(w_cnt + d_cnt + e_cnt), 32'd0);
    exp_q.push_back(8'h5A);
    strobe(0, 1, 0, 0);
    strobe(0, 0, 1, 0);
    send_byte(8'h5A, 1);
    idle(3);
    check("post_rst_writes", 32'(w_cnt), 32'd1);
    check("post_rst_done", 32'(d_cnt), 32'd1);
    check("post_rst_data", 32'(rx_data), 32'h5A);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_sync_ctrl.md
RX_SYNC_CTRL -- requirements
Module: rx_sync_ctrl

Interface
REQ-001 Parameter SFD_TIMEOUT, default 64: maximum bit_valid strobes spent in SYNC before the frame is abandoned; legal range 1..255.
REQ-002 Parameter BYTE_W, default 8: width of each assembled data word.
REQ-003 clk  in  1  system clock; all logic is on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 bit_valid  in  1  one-cycle strobe per recovered bit.
REQ-006 bit_in  in  1  recovered bit; sampled only when bit_valid=1.
REQ-007 pre_h  in  1  preamble correlator high-threshold match.
REQ-008 sfd_h  in  1  start-frame-delimiter correlator high-threshold match.
REQ-009 eof_h  in  1  end-of-frame (idle pattern) correlator high-threshold match.
REQ-010 corr_enb  out  1  correlator shift enable; combinationally equal to bit_valid.
REQ-011 corr_rst  out  1  one-cycle correlator reset pulse.
REQ-012 cardet  out  1  carrier detect; high in SYNC and RECV.
REQ-013 rx_data  out  BYTE_W  last completed data word, LSB received first.
REQ-014 rx_write  out  1  one-cycle strobe; rx_data is valid while it is high.
REQ-015 rx_done  out  1  one-cycle strobe on clean end of frame.
REQ-016 rx_error  out  1  one-cycle strobe on an aborted frame.
REQ-017 state  out  2  encoded state: HUNT=0, SYNC=1, RECV=2, FLUSH=3.

Function
REQ-018 The FSM SHALL have four states, HUNT, SYNC, RECV and FLUSH; inputs pre_h, sfd_h and eof_h are evaluated only on cycles where bit_valid=1.
REQ-019 HUNT: on pre_h, go to SYNC and clear the timeout counter.
REQ-020 SYNC: on sfd_h, go to RECV and clear the bit counter.
REQ-021 SYNC: each bit_valid without sfd_h increments the timeout counter; when the counter reaches SFD_TIMEOUT, pulse rx_error and go to FLUSH.
REQ-022 SYNC: sfd_h on the same strobe as timeout expiry wins; go to RECV with no error.
REQ-023 RECV: each bit_valid shifts bit_in into the MSB of the assembly register (right shift) and increments the bit counter modulo BYTE_W.
REQ-024 RECV: on the BYTE_W-th bit, the registered rx_data takes the completed word and rx_write=1 in the following cycle only (latency: 1 clock after the sampling edge).
REQ-025 RECV: eof_h with bit counter at 0 after the current bit pulses rx_done and goes to FLUSH.
REQ-026 RECV: eof_h with a partial word pulses rx_error, discards the partial word (no rx_write) and goes to FLUSH.
REQ-027 RECV: if eof_h coincides with the completing bit, rx_write and rx_done both pulse in the same cycle, then go to FLUSH.
REQ-028 FLUSH: corr_rst=1 for exactly one cycle, then go unconditionally to HUNT; bit_valid in FLUSH is ignored.
REQ-029 Every output other than rx_data SHALL be a single-cycle pulse or level as defined above; rx_data holds its value between writes.

Reset
REQ-030 Reset forces state to HUNT and clears both counters, the assembly register and rx_data.
REQ-031 While reset is asserted, rx_write, rx_done, rx_error, cardet and corr_rst SHALL be 0.
REQ-032 Reset mid-frame produces no rx_write, rx_done or rx_error pulse.

Configuration
REQ-033 Macro RX_SYNC_TIMEOUT_EN defined: the SYNC timeout of REQ-021 is active.
REQ-034 Macro RX_SYNC_TIMEOUT_EN undefined: the timeout counter is omitted; SYNC leaves only on sfd_h, or on pre_h low for a bit_valid strobe, which returns to HUNT silently with no error.

Verification
REQ-035 The bench SHALL cover: pre_h, then sfd_h, then bits of 0xA5 then 0x3C LSB-first, then eof_h -> rx_write twice with rx_data=0xA5 then 0x3C, then one rx_done, then one corr_rst, then state=0.
REQ-036 The bench SHALL cover: eof_h after 3 bits of a word -> rx_error=1 for one cycle, no rx_write, then FLUSH, then HUNT.
REQ-037 The bench SHALL cover: with RX_SYNC_TIMEOUT_EN, pre_h followed by 64 strobes without sfd_h -> rx_error on the 64th strobe, then corr_rst; without the macro, remains in SYNC while pre_h=1.
REQ-038 The bench SHALL cover: sfd_h on the 64th SYNC strobe -> state=2, no rx_error.
REQ-039 The bench SHALL cover: eof_h on the 8th bit of 0xFF -> rx_write and rx_done in the same cycle, rx_data=0xFF.
REQ-040 The bench SHALL cover: reset asserted after the 5th bit in RECV -> state=0, rx_data=0x00, no strobes; the next frame is received correctly.
